// File: rtl/masked_quad_layer_pipe.sv
// Three-share, second-order masked quadratic layer: non-complete cross terms with refresh,
// then share compression. Two-stage valid/ready pipeline with full backpressure.
module masked_quad_layer_pipe #(
  parameter int WIDTH   = 4,
  parameter int MODE    = 0,
  parameter int REFRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 rnd_valid,
  input  logic [3*WIDTH-1:0]   a,
  input  logic [3*WIDTH-1:0]   b,
  input  logic [3*WIDTH-1:0]   c,
  input  logic [3*WIDTH-1:0]   d,
  input  logic [3*WIDTH-1:0]   rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WIDTH-1:0]   q
);

  logic                          v1;
  logic                          v2;
  logic                          adv1;
  logic                          adv2;
  logic                          rnd_ok;
  logic                          accept;
  logic [2:0][2:0][WIDTH-1:0]    t_d;
  logic [2:0][2:0][WIDTH-1:0]    t_q;
  logic [3*WIDTH-1:0]            q_d;
  logic [3*WIDTH-1:0]            lin_d;
  logic [3*WIDTH-1:0]            diag_d;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign rnd_ok   = (REFRESH == 0) ? 1'b1 : rnd_valid;
  assign accept   = in_valid && in_ready && rnd_ok;

  // Operand the d shares multiply against, and the linear part added on the diagonal.
  assign lin_d  = (MODE == 0) ? c : (b ^ c);
  assign diag_d = (MODE == 0) ? a : (a ^ b);

  // Each term touches only shares i and j; the random mask for pair {i,j} sits in slot i+j-1.
  always_comb begin
    t_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        t_d[i][j] = d[i*WIDTH +: WIDTH] & lin_d[j*WIDTH +: WIDTH];
        if (i == j)
          t_d[i][j] = t_d[i][j] ^ diag_d[i*WIDTH +: WIDTH];
        else if (REFRESH != 0)
          t_d[i][j] = t_d[i][j] ^ rnd[(i+j-1)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    q_d = '0;
    for (int k = 0; k < 3; k++)
      q_d[k*WIDTH +: WIDTH] = t_q[k][0] ^ t_q[k][1] ^ t_q[k][2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      t_q <= '0;
    end else if (adv1) begin
      v1 <= accept;
      if (accept)
        t_q <= t_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      q  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      q  <= q_d;
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_masked_quad_layer_pipe.sv
// Directed bench for masked_quad_layer_pipe: a MODE0 and a MODE1 instance share all inputs;
// results are checked on the unmasked value (XOR of the three q shares).
module tb_masked_quad_layer_pipe;

  localparam int W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            rnd_valid;
  logic            out_ready;
  logic [3*W-1:0]  a, b, c, d, rnd;
  logic            ir0, ir1, ov0, ov1;
  logic [3*W-1:0]  q0, q1;

  int checks   = 0;
  int failures = 0;

  logic [3:0] oa [8];
  logic [3:0] ob [8];
  logic [3:0] oc [8];
  logic [3:0] od [8];

  always #5 clk = ~clk;

  masked_quad_layer_pipe #(.WIDTH(W), .MODE(0), .REFRESH(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .rnd_valid(rnd_valid),
    .a(a), .b(b), .c(c), .d(d), .rnd(rnd), .out_valid(ov0), .out_ready(out_ready), .q(q0)
  );

  masked_quad_layer_pipe #(.WIDTH(W), .MODE(1), .REFRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .rnd_valid(rnd_valid),
    .a(a), .b(b), .c(c), .d(d), .rnd(rnd), .out_valid(ov1), .out_ready(out_ready), .q(q1)
  );

  function automatic logic [3:0] uq(input logic [3*W-1:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction

  function automatic logic [3:0] f0(input logic [3:0] ua, input logic [3:0] uc, input logic [3:0] ud);
    return ua ^ (ud & uc);
  endfunction

  function automatic logic [3:0] f1(input logic [3:0] ua, input logic [3:0] ub,
                                    input logic [3:0] uc, input logic [3:0] ud);
    return ua ^ ub ^ (ud & (ub ^ uc));
  endfunction

  function automatic logic [3*W-1:0] share(input logic [3:0] v);
    logic [3:0] s0, s1;
    s0 = 4'($urandom);
    s1 = 4'($urandom);
    return {v ^ s0 ^ s1, s1, s0};
  endfunction

  task automatic drive_op(input logic [3:0] ua, input logic [3:0] ub,
                          input logic [3:0] uc, input logic [3:0] ud);
    a   = share(ua);
    b   = share(ub);
    c   = share(uc);
    d   = share(ud);
    rnd = 12'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0; rnd = '0;
    #2;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
    checks++; if (q0 !== 12'h000) begin failures++; $display("FAIL reset_q got=%h exp=000", q0); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir0); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1 got=%b exp=0", ov1); end
  endtask

  task automatic test_mode0();
    out_ready = 1'b1;
    drive_op(4'h5, 4'h9, 4'h3, 4'h6);
    in_valid = 1'b1; rnd_valid = 1'b1;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t1_latency1 got=%b exp=0", ov0); end
    tick();
    #1;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t1_latency2 got=%b exp=1", ov0); end
    checks++; if (uq(q0) !== 4'h7) begin failures++; $display("FAIL t1_mode0_value got=%h exp=7", uq(q0)); end
    checks++; if (uq(q1) !== 4'hE) begin failures++; $display("FAIL t1_mode1_value got=%h exp=e", uq(q1)); end
    tick();
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t1_drained got=%b exp=0", ov0); end
  endtask

  task automatic test_mode1_sharings();
    int n = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1003; cyc++) begin
      if (cyc < 1000) begin
        drive_op(4'h5, 4'h9, 4'h3, 4'h6);
        in_valid = 1'b1; rnd_valid = 1'b1;
      end else begin
        in_valid = 1'b0; rnd_valid = 1'b0;
      end
      #1;
      if (ov1) begin
        n++;
        checks++; if (uq(q1) !== 4'hE) begin failures++; $display("FAIL t2_mode1_share got=%h exp=e n=%0d", uq(q1), n); end
        checks++; if (uq(q0) !== 4'h7) begin failures++; $display("FAIL t2_mode0_share got=%h exp=7 n=%0d", uq(q0), n); end
      end
      tick();
    end
    checks++; if (n !== 1000) begin failures++; $display("FAIL t2_result_count got=%0d exp=1000", n); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      oa[i] = 4'(i + 1); ob[i] = 4'(3 * i + 2); oc[i] = 4'(15 - i); od[i] = 4'(i ^ 3);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8) begin
        drive_op(oa[cyc], ob[cyc], oc[cyc], od[cyc]);
        in_valid = 1'b1; rnd_valid = 1'b1;
      end else begin
        in_valid = 1'b0; rnd_valid = 1'b0;
      end
      #1;
      if (cyc < 8) begin
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL t3_in_ready got=%b exp=1 cyc=%0d", ir0, cyc); end
      end
      if (cyc >= 2) begin
        checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t3_out_valid got=%b exp=1 cyc=%0d", ov0, cyc); end
        checks++;
        if (uq(q0) !== f0(oa[cyc-2], oc[cyc-2], od[cyc-2])) begin
          failures++; $display("FAIL t3_order0 got=%h exp=%h cyc=%0d", uq(q0), f0(oa[cyc-2], oc[cyc-2], od[cyc-2]), cyc);
        end
        checks++;
        if (uq(q1) !== f1(oa[cyc-2], ob[cyc-2], oc[cyc-2], od[cyc-2])) begin
          failures++; $display("FAIL t3_order1 got=%h exp=%h cyc=%0d", uq(q1), f1(oa[cyc-2], ob[cyc-2], oc[cyc-2], od[cyc-2]), cyc);
        end
      end else begin
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t3_fill got=%b exp=0 cyc=%0d", ov0, cyc); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int rcv = 0;
    logic [3*W-1:0] q_hold;
    for (int i = 0; i < 5; i++) begin
      oa[i] = 4'(7 * i + 1); ob[i] = 4'(i + 4); oc[i] = 4'(5 * i + 3); od[i] = 4'(13 - 2 * i);
    end
    out_ready = 1'b0;
    drive_op(oa[0], ob[0], oc[0], od[0]);
    in_valid = 1'b1; rnd_valid = 1'b1;
    q_hold = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      checks++; if (ir0 !== (cyc < 2)) begin failures++; $display("FAIL t4_in_ready got=%b exp=%b cyc=%0d", ir0, (cyc < 2), cyc); end
      if (cyc >= 2) begin
        checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t4_out_valid got=%b exp=1 cyc=%0d", ov0, cyc); end
        checks++; if (uq(q0) !== f0(oa[0], oc[0], od[0])) begin failures++; $display("FAIL t4_head got=%h exp=%h", uq(q0), f0(oa[0], oc[0], od[0])); end
        if (cyc == 2) q_hold = q0;
        else begin
          checks++; if (q0 !== q_hold) begin failures++; $display("FAIL t4_q_stable got=%h exp=%h", q0, q_hold); end
        end
      end
      if (in_valid && ir0) idx++;
      tick();
      if (idx < 5) drive_op(oa[idx], ob[idx], oc[idx], od[idx]);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && rcv < 5; cyc++) begin
      in_valid  = (idx < 5);
      rnd_valid = in_valid;
      #1;
      if (ov0) begin
        checks++; if (uq(q0) !== f0(oa[rcv], oc[rcv], od[rcv])) begin failures++; $display("FAIL t4_release0 got=%h exp=%h n=%0d", uq(q0), f0(oa[rcv], oc[rcv], od[rcv]), rcv); end
        checks++; if (uq(q1) !== f1(oa[rcv], ob[rcv], oc[rcv], od[rcv])) begin failures++; $display("FAIL t4_release1 got=%h exp=%h n=%0d", uq(q1), f1(oa[rcv], ob[rcv], oc[rcv], od[rcv]), rcv); end
        rcv++;
      end
      if (in_valid && ir0) idx++;
      tick();
      if (idx < 5) drive_op(oa[idx], ob[idx], oc[idx], od[idx]);
    end
    in_valid = 1'b0; rnd_valid = 1'b0;
    checks++; if (rcv !== 5) begin failures++; $display("FAIL t4_count got=%0d exp=5", rcv); end
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t4_no_duplicate got=%b exp=0", ov0); end
    tick();
  endtask

  task automatic test_rnd_gate();
    out_ready = 1'b1;
    drive_op(4'hC, 4'h2, 4'h5, 4'h7);
    in_valid = 1'b1; rnd_valid = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL t5_in_ready got=%b exp=1 cyc=%0d", ir0, cyc); end
      tick();
      #1;
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t5_no_accept got=%b exp=0 cyc=%0d", ov0, cyc); end
    end
    tick();
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t5_bubble got=%b exp=0", ov0); end
    rnd_valid = 1'b1;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t5_stage1 got=%b exp=0", ov0); end
    tick();
    #1;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t5_out_valid got=%b exp=1", ov0); end
    checks++; if (uq(q0) !== 4'h9) begin failures++; $display("FAIL t5_value0 got=%h exp=9", uq(q0)); end
    checks++; if (uq(q1) !== f1(4'hC, 4'h2, 4'h5, 4'h7)) begin failures++; $display("FAIL t5_value1 got=%h exp=%h", uq(q1), f1(4'hC, 4'h2, 4'h5, 4'h7)); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_op(4'h1, 4'h4, 4'h2, 4'h3);
    in_valid = 1'b1; rnd_valid = 1'b1;
    tick();
    drive_op(4'h6, 4'h5, 4'hE, 4'hB);
    tick();
    in_valid = 1'b0; rnd_valid = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t6_in_flight got=%b exp=1", ov0); end
    rst_n = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t6_async_valid got=%b exp=0", ov0); end
    checks++; if (q0 !== 12'h000) begin failures++; $display("FAIL t6_async_q got=%h exp=000", q0); end
    checks++; if (q1 !== 12'h000) begin failures++; $display("FAIL t6_async_q1 got=%h exp=000", q1); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL t6_in_ready got=%b exp=1", ir0); end
    for (int cyc = 0; cyc < 2; cyc++) begin
      tick();
      #1;
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL t6_no_partial got=%b exp=0 cyc=%0d", ov0, cyc); end
    end
    drive_op(4'hA, 4'h6, 4'hF, 4'h3);
    in_valid = 1'b1; rnd_valid = 1'b1;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b0;
    tick();
    #1;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL t6_next_valid got=%b exp=1", ov0); end
    checks++; if (uq(q0) !== 4'h9) begin failures++; $display("FAIL t6_next_value got=%h exp=9", uq(q0)); end
    checks++; if (uq(q1) !== f1(4'hA, 4'h6, 4'hF, 4'h3)) begin failures++; $display("FAIL t6_next_value1 got=%h exp=%h", uq(q1), f1(4'hA, 4'h6, 4'hF, 4'h3)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_sharings();
    test_back_to_back();
    test_backpressure();
    test_rnd_gate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
